ga23_rom_arbiter: RTL and testbench

- Responder side of the layer tile-ROM fetch interface.
- Serves three tile layers. Each layer issues a single-cycle sdr_req pulse with a 22-bit sdr_addr and expects one 32-bit row back, qualified by sdr_rdy.
- Latches the pulses, arbitrates round-robin, and issues one request at a time to the SDRAM controller port over a level req/ack handshake.
- Routes each returned word to the channel that requested it. Sits between the three layer instances and the SDRAM controller inside the GA23 video block.

---
 rtl/ga23_rom_arbiter.sv | 122 ++++++++++++
 tb/tb_ga23_rom_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ga23_rom_arbiter.sv
// Tile-ROM fetch arbiter for the three GA23 layers: captures request pulses,
// grants round-robin onto a single level req/ack SDRAM port, steers rows back.
`timescale 1ns/1ps
module ga23_rom_arbiter #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [DATA_W-1:0] data_out,
  output logic [2:0]        rdy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              busy
);

  // Handshake: mem_req rises with a stable mem_addr and stays high until the
  // edge that samples mem_ack=1; mem_data is taken on that same edge.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [2:0]        pending;
  logic [ADDR_W-1:0] paddr0;
  logic [ADDR_W-1:0] paddr1;
  logic [ADDR_W-1:0] paddr2;
  logic [1:0]        rr;
  logic [1:0]        grant;
  logic [1:0]        pick;
  logic [ADDR_W-1:0] pick_addr;
  logic [2:0]        clr_mask;

  // First pending channel at or after rr, wrapping 2 -> 0.
  always_comb begin
    pick = 2'd0;
    case (rr)
      2'd1: begin
        if (pending[1])      pick = 2'd1;
        else if (pending[2]) pick = 2'd2;
        else                 pick = 2'd0;
      end
      2'd2: begin
        if (pending[2])      pick = 2'd2;
        else if (pending[0]) pick = 2'd0;
        else                 pick = 2'd1;
      end
      default: begin
        if (pending[0])      pick = 2'd0;
        else if (pending[1]) pick = 2'd1;
        else                 pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    pick_addr = paddr0;
    case (pick)
      2'd1:    pick_addr = paddr1;
      2'd2:    pick_addr = paddr2;
      default: pick_addr = paddr0;
    endcase
  end

  always_comb begin
    clr_mask = 3'b000;
    if (state == S_IDLE && pending != 3'b000) clr_mask = 3'b001 << pick;
  end

  assign busy = mem_req | (|pending);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      pending  <= 3'b000;
      paddr0   <= '0;
      paddr1   <= '0;
      paddr2   <= '0;
      rr       <= 2'd0;
      grant    <= 2'd0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
      data_out <= '0;
      rdy      <= 3'b000;
    end else begin
      // A fresh pulse on the granted channel re-arms it after the clear.
      pending <= (pending & ~clr_mask) | req;
      if (req[0]) paddr0 <= addr0;
      if (req[1]) paddr1 <= addr1;
      if (req[2]) paddr2 <= addr2;
      rdy <= 3'b000;
      case (state)
        S_IDLE: begin
          if (pending != 3'b000) begin
            mem_addr <= pick_addr;
            mem_req  <= 1'b1;
            grant    <= pick;
            rr       <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            data_out <= mem_data;
            rdy      <= 3'b001 << grant;
            mem_req  <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ga23_rom_arbiter.sv
// Bench for ga23_rom_arbiter: directed layer requests, a behavioural SDRAM
// controller, and queue-based checking of memory addresses and returned rows.
`timescale 1ns/1ps
module tb_ga23_rom_arbiter;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [2:0]        req = 3'b000;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [ADDR_W-1:0] addr1 = '0;
  logic [ADDR_W-1:0] addr2 = '0;
  logic [DATA_W-1:0] data_out;
  logic [2:0]        rdy;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              busy;

  ga23_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .data_out(data_out), .rdy(rdy),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_data(mem_data), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // scoreboard queues
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] ctl_data_q[$];
  logic [1:0]        exp_ch_q[$];
  logic [DATA_W-1:0] exp_data_q[$];

  int     ack_delay = 0;
  logic   ctl_force_ack = 1'b0;
  longint t_req = 0;
  longint t_rdy0 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // driver tasks
  task automatic issue(input logic [2:0] r, input logic [ADDR_W-1:0] a0,
                       input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    @(negedge clk);
    req = r; addr0 = a0; addr1 = a1; addr2 = a2;
    t_req = $time;
    @(negedge clk);
    req = 3'b000;
  endtask

  task automatic expect_txn(input logic [1:0] ch, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
    exp_addr_q.push_back(a);
    ctl_data_q.push_back(d);
    exp_ch_q.push_back(ch);
    exp_data_q.push_back(d);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_ch_q.size() != 0) && n < budget);
    @(negedge clk);
    if (busy || exp_ch_q.size() != 0) begin
      n_checks++;
      $display("FAIL idle_timeout: busy=%0b outstanding=%0d after %0d cycles", busy, exp_ch_q.size(), budget);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // SDRAM controller model: acks ack_delay cycles after seeing mem_req
  initial begin
    logic              txn_active;
    logic              after_ack;
    int                wait_cnt;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    txn_active = 1'b0; after_ack = 1'b0; wait_cnt = 0;
    cur_addr = '0; cur_data = '0;
    mem_ack = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (after_ack) begin
        check("mem_req_gap", {31'd0, mem_req}, 32'd0);
        after_ack = 1'b0;
      end else if (txn_active && !mem_req) begin
        txn_active = 1'b0;
      end else if (!txn_active && mem_req) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_mem_req: mem_addr=0x%0h with no transaction expected", mem_addr);
          cur_addr = mem_addr; cur_data = 32'hFFFF_FFFF;
        end else begin
          cur_addr = exp_addr_q.pop_front();
          cur_data = ctl_data_q.pop_front();
          check("mem_addr", {10'd0, mem_addr}, {10'd0, cur_addr});
        end
        wait_cnt = ack_delay;
        txn_active = 1'b1;
      end else if (txn_active) begin
        check("mem_addr_stable", {10'd0, mem_addr}, {10'd0, cur_addr});
      end
      if (txn_active) begin
        if (wait_cnt == 0) begin
          mem_ack = 1'b1;
          mem_data = cur_data;
          txn_active = 1'b0;
          after_ack = 1'b1;
        end else begin
          wait_cnt--;
        end
      end
      if (ctl_force_ack) begin
        mem_ack = 1'b1;
        mem_data = 32'hBAD0_BAD0;
      end
    end
  end

  // response monitor
  initial begin
    logic [1:0]        ch;
    logic [DATA_W-1:0] d;
    forever begin
      @(negedge clk);
      if (rdy[0]) t_rdy0 = $time;
      if (rdy !== 3'b000) begin
        if (exp_ch_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_rdy: rdy=%b data_out=0x%0h, expected no response", rdy, data_out);
        end else begin
          ch = exp_ch_q.pop_front();
          d  = exp_data_q.pop_front();
          check("rdy_channel", {29'd0, rdy}, 32'd1 << ch);
          check("data_out", data_out, d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, no clock edge yet
    #1 reset_n = 1'b0;
    #2;
    check("reset_data_out", data_out, 32'd0);
    check("reset_rdy", {29'd0, rdy}, 32'd0);
    check("reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("reset_mem_addr", {10'd0, mem_addr}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // single request, ack two cycles after mem_req
    ack_delay = 2;
    expect_txn(2'd0, 22'h012340, 32'hDEADBEEF);
    issue(3'b001, 22'h012340, 22'h0, 22'h0);
    wait_idle(100);
    check("single_busy_clear", {31'd0, busy}, 32'd0);
    check("single_mem_req_low", {31'd0, mem_req}, 32'd0);

    // simultaneous requests from reset: order 0,1,2, immediate acks
    apply_reset();
    ack_delay = 0;
    expect_txn(2'd0, 22'h000100, 32'h1111_0100);
    expect_txn(2'd1, 22'h000200, 32'h2222_0200);
    expect_txn(2'd2, 22'h000300, 32'h3333_0300);
    issue(3'b111, 22'h000100, 22'h000200, 22'h000300);
    wait_idle(100);
    check("req_to_rdy_latency", 32'(t_rdy0 - t_req), 32'd30);

    // round-robin: serve ch0, then ch1 wins over ch0
    expect_txn(2'd0, 22'h000400, 32'h4444_0400);
    issue(3'b001, 22'h000400, 22'h0, 22'h0);
    wait_idle(100);
    expect_txn(2'd1, 22'h000420, 32'h5555_0420);
    expect_txn(2'd0, 22'h000410, 32'h6666_0410);
    issue(3'b011, 22'h000410, 22'h000420, 22'h0);
    wait_idle(100);

    // address overwrite while ch0 waits: one ch2 transaction at the later address
    ack_delay = 6;
    expect_txn(2'd0, 22'h001000, 32'h7777_1000);
    expect_txn(2'd2, 22'h003100, 32'h8888_3100);
    issue(3'b001, 22'h001000, 22'h0, 22'h0);
    issue(3'b100, 22'h0, 22'h0, 22'h003000);
    issue(3'b100, 22'h0, 22'h0, 22'h003100);
    wait_idle(200);

    // re-request on the granted channel
    ack_delay = 4;
    expect_txn(2'd1, 22'h000500, 32'h9999_0500);
    expect_txn(2'd1, 22'h000555, 32'hAAAA_0555);
    issue(3'b010, 22'h0, 22'h000500, 22'h0);
    issue(3'b010, 22'h0, 22'h000555, 22'h0);
    wait_idle(200);

    // async reset in WAIT with ch1/ch2 pending: no responses for any of them
    ack_delay = 20;
    exp_addr_q.push_back(22'h000700);
    ctl_data_q.push_back(32'hCCCC_0700);
    issue(3'b001, 22'h000700, 22'h0, 22'h0);
    issue(3'b110, 22'h0, 22'h000710, 22'h000720);
    #2;
    check("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_mem_req", {31'd0, mem_req}, 32'd0);
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_rdy", {29'd0, rdy}, 32'd0);
    check("async_reset_mem_addr", {10'd0, mem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // stray ack while idle
    @(posedge clk);
    #1 ctl_force_ack = 1'b1;
    @(posedge clk);
    #1 ctl_force_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stray_ack_rdy", {29'd0, rdy}, 32'd0);
      check("stray_ack_mem_req", {31'd0, mem_req}, 32'd0);
      check("stray_ack_busy", {31'd0, busy}, 32'd0);
    end
    check("stray_ack_data_out", data_out, 32'd0);
    check("queues_drained", 32'(exp_addr_q.size() + exp_ch_q.size() + ctl_data_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
